// File: rtl/fx3_test_pkg.sv
// Shared types and constants for the FX3 pin tester: FSM encoding, pattern-set codes
// and the per-mode vector count.
package fx3_test_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StReset,
    StWaitRdy,
    StDrive,
    StReq,
    StCheck,
    StRel,
    StNext,
    StDone
  } state_e;

  localparam logic [1:0] MODE_WALK1 = 2'd0;
  localparam logic [1:0] MODE_WALK0 = 2'd1;
  localparam logic [1:0] MODE_ALT   = 2'd2;
  localparam logic [1:0] MODE_CNT   = 2'd3;

  localparam int unsigned CNT_LEN = 256;

  function automatic int unsigned num_vectors(input logic [1:0] m, input int unsigned width);
    int unsigned n;
    case (m)
      MODE_WALK1: n = width;
      MODE_WALK0: n = width;
      MODE_ALT:   n = 2;
      default:    n = CNT_LEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fx3_pin_tester_if.sv
// FX3-facing pin bundle: test bus, intr/ack handshake, readiness inputs, reset and GPIF clock.
interface fx3_pin_tester_if #(
  parameter int unsigned WIDTH = 23
);
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_in;
  logic             intr;
  logic             ack;
  logic             fx3_ready;
  logic             gpl_status;
  logic             hw_rst;
  logic             gpl_clk;

  modport master (
    output data_out, intr, hw_rst, gpl_clk,
    input  data_in, ack, fx3_ready, gpl_status
  );

  modport slave (
    input  data_out, intr, hw_rst, gpl_clk,
    output data_in, ack, fx3_ready, gpl_status
  );
endinterface

// File: rtl/fx3_sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous FX3 status/handshake inputs.
module fx3_sync_2ff (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;
endmodule

// File: rtl/fx3_pin_tester.sv
// FX3 pin tester: resets the FX3, waits for it to come up, then walks a selectable pattern
// set across the pin bus with a four-phase intr/ack handshake and accumulates mismatches.
module fx3_pin_tester
  import fx3_test_pkg::*;
#(
  parameter int unsigned WIDTH          = 23,
  parameter int unsigned RST_CYCLES     = 400,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CLK_DIV_LOG2   = 1
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 pll_lock,
  fx3_pin_tester_if.master     fx3,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [WIDTH-1:0]     err_mask,
  output logic                 timeout_err
);

  localparam int unsigned CNT_MAX  = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);
  localparam int unsigned NVEC_MAX = (WIDTH > CNT_LEN) ? WIDTH : CNT_LEN;
  localparam int unsigned IW       = $clog2(NVEC_MAX);

  logic ack_s, rdy_s, gpl_s;

  fx3_sync_2ff u_sync_ack (.clk(clk), .arst(arst), .d(fx3.ack),        .q(ack_s));
  fx3_sync_2ff u_sync_rdy (.clk(clk), .arst(arst), .d(fx3.fx3_ready),  .q(rdy_s));
  fx3_sync_2ff u_sync_gpl (.clk(clk), .arst(arst), .d(fx3.gpl_status), .q(gpl_s));

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [1:0]       mode_q, mode_d;
  logic             abort_q, abort_d;
  logic             tested_q, tested_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             intr_q, intr_d;
  logic             hw_rst_q, hw_rst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [15:0]      err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic             timeout_q, timeout_d;
  logic [CLK_DIV_LOG2-1:0] div_q, div_d;
  logic             gpl_clk_q;

  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] mismatch;
  logic             counting;
  logic             tmo_hit;
  logic             last_vec;

  always_comb begin
    vec = '0;
    unique case (mode_q)
      MODE_WALK1: vec = WIDTH'(1) << idx_q;
      MODE_WALK0: vec = ~(WIDTH'(1) << idx_q);
      MODE_ALT: begin
        // Vector 0 puts ones on even bits, vector 1 on odd bits.
        for (int b = 0; b < WIDTH; b++) vec[b] = (b[0] == 1'b0) ^ idx_q[0];
      end
      MODE_CNT:   vec = WIDTH'(idx_q);
    endcase
  end

  assign counting = (state_q == StReset) || (state_q == StWaitRdy) ||
                    (state_q == StReq)   || (state_q == StRel);
  assign tmo_hit  = 32'(cnt_q) >= TIMEOUT_CYCLES - 1;
  assign last_vec = 32'(idx_q) == num_vectors(mode_q, WIDTH) - 1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    abort_d    = abort_q;
    tested_d   = tested_q;
    data_out_d = data_out_q;
    intr_d     = intr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    err_mask_d = err_mask_q;
    timeout_d  = timeout_q;
    mismatch   = fx3.data_in ^ data_out_q;

    if (state_q != StIdle && state_q != StDone && !pll_lock) begin
      state_d = StDone;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && pll_lock) begin
            state_d    = StReset;
            mode_d     = mode;
            idx_d      = '0;
            abort_d    = 1'b0;
            tested_d   = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            err_cnt_d  = '0;
            err_mask_d = '0;
            timeout_d  = 1'b0;
          end
        end
        StReset: begin
          if (32'(cnt_q) == RST_CYCLES - 1) state_d = StWaitRdy;
        end
        StWaitRdy: begin
          if (rdy_s && gpl_s) begin
            state_d = StDrive;
          end else if (tmo_hit) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end
        end
        StDrive: begin
          data_out_d = vec;
          state_d    = StReq;
        end
        StReq: begin
          // intr rises one cycle into REQ so the bus has settled before the request.
          intr_d = 1'b1;
          if (ack_s) begin
            state_d = StCheck;
          end else if (tmo_hit) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end
        end
        StCheck: begin
          if (|mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            err_mask_d = err_mask_q | mismatch;
          end
          state_d = StRel;
        end
        StRel: begin
          intr_d = 1'b0;
          if (!ack_s) begin
            state_d = StNext;
          end else if (tmo_hit) begin
            state_d   = StDone;
            timeout_d = 1'b1;
          end
        end
        StNext: begin
          if (last_vec) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StDrive;
          end
        end
        StDone: begin
          data_out_d = '0;
          intr_d     = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          pass_d     = (err_cnt_q == 16'd0) && !timeout_q && !abort_q;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    cnt_d    = (counting && state_d == state_q) ? cnt_q + CW'(1) : '0;
    // Held in reset until the first test has run, and for the whole RESET phase of each test.
    hw_rst_d = (state_d == StReset) || !tested_d;
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      mode_q     <= MODE_WALK1;
      abort_q    <= 1'b0;
      tested_q   <= 1'b0;
      data_out_q <= '0;
      intr_q     <= 1'b0;
      hw_rst_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      err_mask_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      abort_q    <= abort_d;
      tested_q   <= tested_d;
      data_out_q <= data_out_d;
      intr_q     <= intr_d;
      hw_rst_q   <= hw_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      err_mask_q <= err_mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign div_d = div_q + CLK_DIV_LOG2'(1);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      div_q     <= '0;
      gpl_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      gpl_clk_q <= div_d[CLK_DIV_LOG2-1];
    end
  end

  assign fx3.data_out = data_out_q;
  assign fx3.intr     = intr_q;
  assign fx3.hw_rst   = hw_rst_q;
  assign fx3.gpl_clk  = gpl_clk_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign err_mask     = err_mask_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_fx3_pin_tester.sv
// Directed bench for fx3_pin_tester with a loopback FX3 model (ack follows intr by 3 cycles)
// and injectable pin faults.
module tb_fx3_pin_tester;
  import fx3_test_pkg::*;

  localparam int unsigned W = 23;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         pll_lock = 1'b1;
  logic         busy, done, pass, timeout_err;
  logic [15:0]  err_cnt;
  logic [W-1:0] err_mask;

  logic [W-1:0] stuck0 = '0;
  logic         short34 = 1'b0;
  logic [2:0]   ack_pipe = '0;

  int n_chk = 0;
  int n_bad = 0;
  int r_hs, r_rst_hi, r_span, r_lat;

  fx3_pin_tester_if #(.WIDTH(W)) fx3 ();

  fx3_pin_tester #(
    .WIDTH(W),
    .RST_CYCLES(8),
    .TIMEOUT_CYCLES(100),
    .CLK_DIV_LOG2(1)
  ) dut (
    .clk(clk),
    .arst(arst),
    .start(start),
    .mode(mode),
    .pll_lock(pll_lock),
    .fx3(fx3),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .err_mask(err_mask),
    .timeout_err(timeout_err)
  );

  always #12 clk = ~clk;

  // Loopback with optional stuck-at-0 bits and a wired-AND short between bits 3 and 4.
  always_comb begin
    logic [W-1:0] v;
    v = fx3.data_out & ~stuck0;
    if (short34) begin
      v[3] = v[3] & v[4];
      v[4] = v[3];
    end
    fx3.data_in = v;
  end

  initial begin
    fx3.ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ack_pipe = {ack_pipe[1:0], fx3.intr};
      fx3.ack  = ack_pipe[2];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start, then samples on falling edges until done; mode is disturbed after start.
  task automatic run_test(input logic [1:0] m, input int abort_at, input bit spam);
    bit fin, in_rst, prev_intr;
    int fall_c, drop_c;
    r_hs = 0; r_rst_hi = 0; r_span = -1; r_lat = -1;
    fin = 1'b0; in_rst = 1'b1; prev_intr = 1'b0; fall_c = -1; drop_c = -1;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      if (in_rst) begin
        if (fx3.hw_rst) r_rst_hi++;
        else begin
          in_rst = 1'b0;
          fall_c = c;
        end
      end
      if (fx3.intr && !prev_intr) r_hs++;
      prev_intr = fx3.intr;
      if (done) begin
        fin = 1'b1;
        if (fall_c >= 0) r_span = c - fall_c;
        if (drop_c >= 0) r_lat = c - drop_c;
      end else begin
        start = spam && (c == 40 || c == 120);
        if (c == 0) mode = m ^ 2'b01;
        if (abort_at > 0 && r_hs == abort_at && drop_c < 0) begin
          pll_lock = 1'b0;
          drop_c   = c;
        end
      end
    end
    start = 1'b0;
    if (!fin) check_eq("run_finished", 32'(done), 32'd1);
  endtask

  initial begin
    bit seen;
    fx3.fx3_ready  = 1'b1;
    fx3.gpl_status = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_data_out", 32'(fx3.data_out), 32'd0);
    check_eq("rst_intr", 32'(fx3.intr), 32'd0);
    check_eq("rst_hw_rst", 32'(fx3.hw_rst), 32'd1);
    check_eq("rst_gpl_clk", 32'(fx3.gpl_clk), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_err_mask", 32'(err_mask), 32'd0);
    check_eq("rst_timeout", 32'(timeout_err), 32'd0);
    arst = 1'b1;
    @(negedge clk);
    check_eq("gpl_clk_hi", 32'(fx3.gpl_clk), 32'd1);
    @(negedge clk);
    check_eq("gpl_clk_lo", 32'(fx3.gpl_clk), 32'd0);
    check_eq("hw_rst_pre_test", 32'(fx3.hw_rst), 32'd1);

    // Walking-one with stray start pulses mid-test.
    run_test(MODE_WALK1, 0, 1'b1);
    check_eq("w1_rst_cycles", 32'(r_rst_hi), 32'd8);
    check_eq("w1_handshakes", 32'(r_hs), 32'd23);
    check_eq("w1_pass", 32'(pass), 32'd1);
    check_eq("w1_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("w1_err_mask", 32'(err_mask), 32'd0);
    check_eq("w1_timeout", 32'(timeout_err), 32'd0);
    check_eq("w1_busy", 32'(busy), 32'd0);
    check_eq("w1_data_out", 32'(fx3.data_out), 32'd0);
    check_eq("w1_hw_rst_idle", 32'(fx3.hw_rst), 32'd0);

    stuck0 = W'(1) << 5;
    run_test(MODE_WALK0, 0, 1'b0);
    stuck0 = '0;
    check_eq("w0_rst_cycles", 32'(r_rst_hi), 32'd8);
    check_eq("w0_handshakes", 32'(r_hs), 32'd23);
    check_eq("w0_err_cnt", 32'(err_cnt), 32'd22);
    check_eq("w0_err_mask", 32'(err_mask), 32'h20);
    check_eq("w0_pass", 32'(pass), 32'd0);

    short34 = 1'b1;
    run_test(MODE_ALT, 0, 1'b0);
    short34 = 1'b0;
    check_eq("alt_handshakes", 32'(r_hs), 32'd2);
    check_eq("alt_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("alt_err_mask", 32'(err_mask), 32'h18);
    check_eq("alt_pass", 32'(pass), 32'd0);

    fx3.fx3_ready = 1'b0;
    run_test(MODE_CNT, 0, 1'b0);
    fx3.fx3_ready = 1'b1;
    check_eq("tmo_flag", 32'(timeout_err), 32'd1);
    check_eq("tmo_done", 32'(done), 32'd1);
    check_eq("tmo_pass", 32'(pass), 32'd0);
    check_eq("tmo_intr", 32'(fx3.intr), 32'd0);
    check_eq("tmo_data_out", 32'(fx3.data_out), 32'd0);
    check_eq("tmo_span", 32'(r_span), 32'd101);
    check_eq("tmo_handshakes", 32'(r_hs), 32'd0);

    run_test(MODE_CNT, 101, 1'b0);
    check_eq("abort_latency", 32'(r_lat), 32'd2);
    check_eq("abort_handshakes", 32'(r_hs), 32'd101);
    check_eq("abort_pass", 32'(pass), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("abort_timeout", 32'(timeout_err), 32'd0);

    // start without PLL lock must be ignored.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("nolock_busy", 32'(busy), 32'd0);
    check_eq("nolock_done", 32'(done), 32'd1);

    pll_lock = 1'b1;
    run_test(MODE_CNT, 0, 1'b0);
    check_eq("cnt_handshakes", 32'(r_hs), 32'd256);
    check_eq("cnt_pass", 32'(pass), 32'd1);
    check_eq("cnt_err_cnt", 32'(err_cnt), 32'd0);

    // Asynchronous reset while a request is outstanding.
    @(negedge clk);
    start = 1'b1;
    mode  = MODE_WALK1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (fx3.intr) seen = 1'b1;
    end
    check_eq("arst_intr_seen", 32'(fx3.intr), 32'd1);
    arst = 1'b0;
    #1;
    check_eq("arst_intr", 32'(fx3.intr), 32'd0);
    check_eq("arst_hw_rst", 32'(fx3.hw_rst), 32'd1);
    check_eq("arst_data_out", 32'(fx3.data_out), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    arst = 1'b1;
    run_test(MODE_WALK1, 0, 1'b1);
    check_eq("post_arst_handshakes", 32'(r_hs), 32'd23);
    check_eq("post_arst_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
